// File: rtl/piano_pkg.sv
// Shared constants for the piano tone generator and its receive-side decoder.
// Holds the octave-0 period table (clk cycles per tone period at CLK_HZ), key and
// octave limits, the decoder FSM state type and the decode result record.
package piano_pkg;

    localparam int CLK_HZ     = 1_000_000;
    localparam int NUM_KEYS   = 12;
    localparam int MAX_OCTAVE = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_MATCH,
        ST_COMMIT
    } dec_state_t;

    // An invalid decode is all-zero, so it matches the cleared output state.
    typedef struct packed {
        logic       valid;
        logic [3:0] key;
        logic [3:0] oct;
    } dec_result_t;

    // round(CLK_HZ / f_octave0) for keys C..B.
    function automatic logic [15:0] period_o0(input logic [3:0] key);
        logic [15:0] p;
        case (key)
            4'd0:    p = 16'd61156;
            4'd1:    p = 16'd57723;
            4'd2:    p = 16'd54484;
            4'd3:    p = 16'd51426;
            4'd4:    p = 16'd48540;
            4'd5:    p = 16'd45815;
            4'd6:    p = 16'd43244;
            4'd7:    p = 16'd40817;
            4'd8:    p = 16'd38526;
            4'd9:    p = 16'd36364;
            4'd10:   p = 16'd34323;
            4'd11:   p = 16'd32396;
            default: p = 16'd0;
        endcase
        return p;
    endfunction

    // Divider value used by the piano side: each octave halves the period.
    function automatic logic [15:0] tone_period(input logic [3:0] key, input logic [3:0] oct);
        return period_o0(key) >> oct;
    endfunction

    // Key j maps to bit (11-j), C in the MSB.
    function automatic logic [11:0] key_to_onehot(input logic [3:0] key);
        return 12'h800 >> key;
    endfunction

endpackage

// File: rtl/tone_decoder_if.sv
// Tone decoder signal bundle.
//   tone_in     : piano square-wave output (asynchronous)
//   key_onehot  : decoded key, one-hot, C = bit 11
//   octave      : decoded octave 0..8
//   note_valid  : key_onehot/octave hold a confirmed note
//   silent      : no tone edge for the full counter range
//   note_strobe : one-cycle pulse when key_onehot, octave or note_valid change
// master = tone source / monitor, slave = decoder.
interface tone_decoder_if;
    logic        tone_in;
    logic [11:0] key_onehot;
    logic [3:0]  octave;
    logic        note_valid;
    logic        silent;
    logic        note_strobe;

    modport master (
        output tone_in,
        input  key_onehot, octave, note_valid, silent, note_strobe
    );

    modport slave (
        input  tone_in,
        output key_onehot, octave, note_valid, silent, note_strobe
    );
endinterface

// File: rtl/tone_period_meter.sv
// Measures clk cycles between rising edges of an asynchronous tone.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_tone         : raw tone input
//   o_edge         : one-cycle pulse on a synchronised rising edge
//   o_period       : cycles since the previous edge, valid with o_edge
//   o_timeout      : counter saturated with no edge (silence)
module tone_period_meter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tone,
    output logic             o_edge,
    output logic [CNT_W-1:0] o_period,
    output logic             o_timeout
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_sync;
    logic             r_sync_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync   <= {r_sync[0], i_tone};
            r_sync_d <= r_sync[1];
            // Restart at 1 so the value seen at the next edge equals the period.
            if (o_edge)
                r_cnt <= CNT_W'(1);
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_edge    = r_sync[1] & ~r_sync_d;
    assign o_period  = r_cnt;
    assign o_timeout = (r_cnt == CNT_MAX) & ~o_edge;

endmodule

// File: rtl/tone_decoder.sv
// Recovers key and octave from the period of the piano square-wave output.
//   clk, rst_n : system clock, async active-low reset
//   bus        : tone_decoder_if slave (tone_in in; key/octave/status out)
//
// state     | meaning
// ST_IDLE   | waiting for an armed rising edge, captures the period
// ST_NORM   | doubling the period up to the octave-0 range, one step per cycle
// ST_MATCH  | comparing against one key period per cycle
// ST_COMMIT | confirm-count update and output load
module tone_decoder
    import piano_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TOL     = 768,
    parameter int CONFIRM = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_decoder_if.slave bus
);
    localparam int P_W  = CNT_W + 1;
    localparam int CF_W = $clog2(CONFIRM + 1);
    localparam logic [CF_W-1:0] CONFIRM_V = CF_W'(CONFIRM);

    logic             w_edge;
    logic             w_timeout;
    logic [CNT_W-1:0] w_period;

    dec_state_t       r_state, w_state_nxt;
    logic [P_W-1:0]   r_p;
    logic [3:0]       r_oct;
    logic [3:0]       r_k;
    dec_result_t      r_res;
    dec_result_t      r_prev;
    logic [CF_W-1:0]  r_confirm;
    logic             r_armed;
    logic [11:0]      r_key_onehot;
    logic [3:0]       r_octave;
    logic             r_note_valid;
    logic             r_silent;
    logic             r_note_strobe;

    logic [P_W-1:0]   w_norm_th;
    logic [P_W-1:0]   w_ref;
    logic [P_W-1:0]   w_diff;
    logic             w_norm_ok;
    logic             w_hit;
    logic             w_same;
    logic             w_changed;
    logic [CF_W-1:0]  w_confirm_nxt;
    logic [11:0]      w_res_onehot;

    tone_period_meter #(.CNT_W(CNT_W)) u_meter (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tone    (bus.tone_in),
        .o_edge    (w_edge),
        .o_period  (w_period),
        .o_timeout (w_timeout)
    );

    // Everything at or above the lowest key window already sits in octave 0.
    assign w_norm_th    = P_W'(period_o0(4'(NUM_KEYS - 1))) - P_W'(TOL);
    assign w_norm_ok    = (r_p >= w_norm_th);
    assign w_ref        = P_W'(period_o0(r_k));
    assign w_diff       = (r_p >= w_ref) ? (r_p - w_ref) : (w_ref - r_p);
    assign w_hit        = (w_diff <= P_W'(TOL));

    assign w_res_onehot = r_res.valid ? key_to_onehot(r_res.key) : 12'd0;
    assign w_same       = (r_confirm != '0) && (r_res == r_prev);
    assign w_confirm_nxt = !w_same                  ? CF_W'(1)  :
                           (r_confirm == CONFIRM_V) ? r_confirm : r_confirm + 1'b1;
    assign w_changed    = (w_res_onehot != r_key_onehot) || (r_res.oct != r_octave) ||
                          (r_res.valid != r_note_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_edge && r_armed) w_state_nxt = ST_NORM;
            ST_NORM:   if (w_norm_ok) w_state_nxt = ST_MATCH;
                       else if (r_oct == 4'(MAX_OCTAVE)) w_state_nxt = ST_COMMIT;
            ST_MATCH:  if (w_hit || r_k == 4'(NUM_KEYS - 1)) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p           <= '0;
            r_oct         <= '0;
            r_k           <= '0;
            r_res         <= '0;
            r_prev        <= '0;
            r_confirm     <= '0;
            r_armed       <= 1'b0;
            r_key_onehot  <= '0;
            r_octave      <= '0;
            r_note_valid  <= 1'b0;
            r_silent      <= 1'b1;
            r_note_strobe <= 1'b0;
        end else begin
            r_note_strobe <= 1'b0;
            case (r_state)
                // Edges arriving while busy are dropped; the meter restarts anyway.
                ST_IDLE: if (w_edge && r_armed) begin
                    r_p   <= P_W'(w_period);
                    r_oct <= '0;
                    r_k   <= '0;
                end
                ST_NORM: if (!w_norm_ok) begin
                    if (r_oct == 4'(MAX_OCTAVE)) begin
                        r_res <= '0;
                    end else begin
                        r_p   <= r_p << 1;
                        r_oct <= r_oct + 4'd1;
                    end
                end
                ST_MATCH: begin
                    if (w_hit)
                        r_res <= {1'b1, r_k, r_oct};
                    else if (r_k == 4'(NUM_KEYS - 1))
                        r_res <= '0;
                    else
                        r_k <= r_k + 4'd1;
                end
                ST_COMMIT: begin
                    r_confirm <= w_confirm_nxt;
                    r_prev    <= r_res;
                    if (w_confirm_nxt == CONFIRM_V) begin
                        r_key_onehot  <= w_res_onehot;
                        r_octave      <= r_res.oct;
                        r_note_valid  <= r_res.valid;
                        r_note_strobe <= w_changed;
                    end
                end
                default: ;
            endcase

            // Silence overrides any decode activity in the same cycle.
            if (w_timeout) begin
                r_armed       <= 1'b0;
                r_confirm     <= '0;
                r_silent      <= 1'b1;
                r_key_onehot  <= '0;
                r_octave      <= '0;
                r_note_valid  <= 1'b0;
                r_note_strobe <= r_note_valid || (r_key_onehot != '0) || (r_octave != '0);
            end else if (w_edge && !r_armed) begin
                r_armed  <= 1'b1;
                r_silent <= 1'b0;
            end
        end
    end

    assign bus.key_onehot  = r_key_onehot;
    assign bus.octave      = r_octave;
    assign bus.note_valid  = r_note_valid;
    assign bus.silent      = r_silent;
    assign bus.note_strobe = r_note_strobe;

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder: square waves of chosen periods are played,
// and a behavioural model decides key/octave/valid/silent and the strobe count.
module tb_tone_decoder;
    localparam int TOL     = 768;
    localparam int CONFIRM = 2;
    localparam int TH      = 32396 - TOL;

    int per_o0 [12] = '{61156, 57723, 54484, 51426, 48540, 45815,
                        43244, 40817, 38526, 36364, 34323, 32396};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tone_decoder_if bus();

    tone_decoder #(.CNT_W(16), .TOL(TOL), .CONFIRM(CONFIRM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt = 0;

    always @(negedge clk) if (bus.note_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

    // model state
    bit          m_armed;
    int          m_cnt;
    int          m_last;
    int          m_prev_period;
    logic [11:0] m_oh;
    int          m_oct;
    bit          m_valid;
    bit          m_silent;
    int          m_strobes;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns key*16+octave, or -1 when the period decodes to nothing.
    function automatic int ref_decode(input int p);
        longint np;
        for (int o = 0; o <= 8; o++) begin
            np = longint'(p) * (longint'(1) << o);
            if (np >= TH) begin
                for (int k = 0; k < 12; k++)
                    if ((np > per_o0[k] ? np - per_o0[k] : per_o0[k] - np) <= TOL)
                        return k * 16 + o;
                return -1;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_cnt = 0; m_last = -1; m_prev_period = 0;
        m_oh = '0; m_oct = 0; m_valid = 0; m_silent = 1;
    endtask

    task automatic model_edge();
        int r;
        logic [11:0] oh;
        int oc;
        bit v;
        if (!m_armed) begin
            m_armed  = 1;
            m_silent = 0;
        end else begin
            r = ref_decode(m_prev_period);
            if (m_cnt > 0 && r == m_last) m_cnt = (m_cnt < CONFIRM) ? m_cnt + 1 : CONFIRM;
            else m_cnt = 1;
            m_last = r;
            if (m_cnt == CONFIRM) begin
                v  = (r >= 0);
                oh = v ? (12'd1 << (11 - r / 16)) : 12'd0;
                oc = v ? r % 16 : 0;
                if (oh != m_oh || oc != m_oct || v != m_valid) m_strobes++;
                m_oh = oh; m_oct = oc; m_valid = v;
            end
        end
    endtask

    task automatic model_timeout();
        if (m_valid || m_oh != 0 || m_oct != 0) m_strobes++;
        m_oh = '0; m_oct = 0; m_valid = 0; m_silent = 1; m_armed = 0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        #1;
        check_val({tag, "_key"},     32'(bus.key_onehot), 32'(m_oh));
        check_val({tag, "_oct"},     32'(bus.octave),     32'(m_oct));
        check_val({tag, "_valid"},   32'(bus.note_valid), 32'(m_valid));
        check_val({tag, "_silent"},  32'(bus.silent),     32'(m_silent));
        check_val({tag, "_strobes"}, 32'(strobe_cnt),     32'(m_strobes));
    endtask

    // One tone period starting with a rising edge; checked just before the next edge.
    task automatic play(input int p, input string tag);
        model_edge();
        bus.tone_in = 1'b1;
        repeat (p / 2) @(negedge clk);
        bus.tone_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
        m_prev_period = p;
        check_all(tag);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int sel, k, o, p, j;
        bus.tone_in = 1'b0;
        m_strobes = 0;
        model_reset();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");
        check_val("reset_silent", 32'(bus.silent), 32'd1);
        repeat (200) @(negedge clk);
        check_all("idle");

        // B8, the shortest legal period
        for (int i = 0; i < 3; i++) play(127, "b8");
        check_val("b8_key_c", 32'(bus.key_onehot), 32'h001);
        check_val("b8_oct_c", 32'(bus.octave), 32'd8);
        check_val("b8_valid_c", 32'(bus.note_valid), 32'd1);

        // reset while the next B8 period is in the key search
        bus.tone_in = 1'b1;
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_key", 32'(bus.key_onehot), 32'd0);
        check_val("arst_oct", 32'(bus.octave), 32'd0);
        check_val("arst_valid", 32'(bus.note_valid), 32'd0);
        check_val("arst_silent", 32'(bus.silent), 32'd1);
        bus.tone_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // random notes in octaves 7..8 (with jitter) and arbitrary short periods
        for (int t = 0; t < 8; t++) begin
            sel = int'($urandom_range(0, 3));
            if (sel != 0) begin
                k = int'($urandom_range(0, 11));
                o = int'($urandom_range(7, 8));
                j = int'($urandom_range(0, 4));
                p = ((per_o0[k] + (1 << (o - 1))) >> o) + j - 2;
            end else begin
                p = int'($urandom_range(60, 500));
            end
            for (int i = 0; i < 3; i++) play(p, "rand");
        end

        // 131 lands between the A# and B windows; 60 runs out of octaves
        for (int i = 0; i < 3; i++) play(131, "gap");
        check_val("gap_valid_c", 32'(bus.note_valid), 32'd0);
        check_val("gap_key_c", 32'(bus.key_onehot), 32'd0);
        for (int i = 0; i < 3; i++) play(60, "ovf");
        check_val("ovf_valid_c", 32'(bus.note_valid), 32'd0);

        // A4
        s0 = strobe_cnt;
        for (int i = 0; i < 3; i++) play(2273, "a4");
        check_val("a4_key_c", 32'(bus.key_onehot), 32'h004);
        check_val("a4_oct_c", 32'(bus.octave), 32'd4);
        check_val("a4_valid_c", 32'(bus.note_valid), 32'd1);
        check_val("a4_one_strobe", 32'(strobe_cnt - s0), 32'd1);

        // switch to C4: one C4 period is not enough
        s0 = strobe_cnt;
        for (int i = 0; i < 2; i++) play(3822, "c4_first");
        check_val("c4_hold_key", 32'(bus.key_onehot), 32'h004);
        check_val("c4_hold_strobe", 32'(strobe_cnt - s0), 32'd0);
        model_edge();
        bus.tone_in = 1'b1;
        repeat (50) @(negedge clk);
        check_all("c4_second");
        check_val("c4_key_c", 32'(bus.key_onehot), 32'h800);
        check_val("c4_oct_c", 32'(bus.octave), 32'd4);
        check_val("c4_one_strobe", 32'(strobe_cnt - s0), 32'd1);

        // stop the tone
        bus.tone_in = 1'b0;
        s0 = strobe_cnt;
        repeat (65600) @(negedge clk);
        model_timeout();
        check_all("silence");
        check_val("sil_silent_c", 32'(bus.silent), 32'd1);
        check_val("sil_key_c", 32'(bus.key_onehot), 32'd0);
        check_val("sil_one_strobe", 32'(strobe_cnt - s0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
